// File: rtl/ike_pkg.sv
// Shared constants for the speed/divider path: FSM encoding, default operand width,
// and the iteration-counter width helper.
package ike_pkg;

    localparam int DIV_WIDTH = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DONE  = 2'd2,
        S_ROUND = 2'd3
    } div_state_e;

    // The counter has to hold the value WIDTH itself, not just WIDTH-1.
    function automatic int iter_cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    localparam int DIV_CNT_W = iter_cnt_width(DIV_WIDTH);

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits, and shift the quotient bit in.
module div_step
    import ike_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] r_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] r_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0]   r_shift;
    logic [WIDTH-1:0] r_diff;
    logic             fits;

    // The true difference is below the divisor whenever it fits, so the low
    // WIDTH bits of the subtraction are exact.
    always_comb begin
        r_shift = {r_in, q_in[WIDTH-1]};
        fits    = (r_shift >= {1'b0, d_in});
        r_diff  = r_shift[WIDTH-1:0] - d_in;
        r_next  = fits ? r_diff : r_shift[WIDTH-1:0];
        q_next  = {q_in[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock, start/busy/ready
// handshake. Define ROUND_NEAREST_EN for a round-to-nearest quotient (one extra cycle).
module seq_divider
    import ike_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             ready,
    output logic             div_zero
);

    localparam int CW = iter_cnt_width(WIDTH);

    div_state_e       state_q, state_d;
    logic [WIDTH-1:0] part_q, part_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;
    logic             div_zero_q, div_zero_d;
    logic [WIDTH-1:0] step_r, step_q;
`ifdef ROUND_NEAREST_EN
    logic             round_up;
`endif

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .r_in   (part_q),
        .q_in   (quo_q),
        .d_in   (dvs_q),
        .r_next (step_r),
        .q_next (step_q)
    );

    always_comb begin
        state_d     = state_q;
        part_d      = part_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        result_d    = result_q;
        remainder_d = remainder_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        ready_d     = ready_q;
        div_zero_d  = div_zero_q;
`ifdef ROUND_NEAREST_EN
        round_up    = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    quo_d   = dividend;
                    dvs_d   = divisor;
                    part_d  = '0;
                    cnt_d   = CW'(WIDTH);
                    busy_d  = 1'b1;
                    ready_d = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                part_d = step_r;
                quo_d  = step_q;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
`ifdef ROUND_NEAREST_EN
                    state_d     = S_ROUND;
`else
                    busy_d      = 1'b0;
                    ready_d     = 1'b1;
                    result_d    = step_q;
                    remainder_d = step_r;
                    div_zero_d  = (dvs_q == '0);
                    state_d     = S_DONE;
`endif
                end
            end
`ifdef ROUND_NEAREST_EN
            S_ROUND: begin
                // Quotient all-ones cannot be bumped; a zero divisor also lands here.
                round_up    = (dvs_q != '0) && ({part_q, 1'b0} >= {1'b0, dvs_q})
                              && (quo_q != '1);
                result_d    = quo_q + WIDTH'(round_up);
                remainder_d = part_q;
                div_zero_d  = (dvs_q == '0);
                busy_d      = 1'b0;
                ready_d     = 1'b1;
                state_d     = S_DONE;
            end
`endif
            S_DONE: begin
                if (!start) begin
                    ready_d    = 1'b0;
                    div_zero_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            part_q      <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            result_q    <= '0;
            remainder_q <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b0;
            div_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            part_q      <= part_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            result_q    <= result_d;
            remainder_q <= remainder_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
            div_zero_q  <= div_zero_d;
        end
    end

    assign result    = result_q;
    assign remainder = remainder_q;
    assign busy      = busy_q;
    assign ready     = ready_q;
    assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: a driver issues requests and pushes expected results,
// a monitor pops and compares on every rising ready.
module tb_seq_divider;

    localparam int W = 16;
`ifdef ROUND_NEAREST_EN
    localparam int LAT = W + 1;
    localparam bit RND = 1'b1;
`else
    localparam int LAT = W;
    localparam bit RND = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend, divisor, result, remainder;
    logic         busy, ready, div_zero;

    int checks = 0;
    int errors = 0;
    logic [2*W:0] exp_q[$];
    logic ready_prev = 1'b0;

    seq_divider #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .result    (result),
        .remainder (remainder),
        .busy      (busy),
        .ready     (ready),
        .div_zero  (div_zero)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        logic [2*W:0] e;
        if (!rst) begin
            check("busy_ready_exclusive", {31'd0, busy & ready}, 32'd0);
            if (ready && !ready_prev) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ready", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("result", {16'd0, result}, {16'd0, e[2*W-1:W]});
                    check("remainder", {16'd0, remainder}, {16'd0, e[W-1:0]});
                    check("div_zero", {31'd0, div_zero}, {31'd0, e[2*W]});
                end
            end
        end
        ready_prev <= ready;
    end

    // driver
    task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] er, input logic [W-1:0] erem,
                          input logic edz, input bit hold);
        int  n;
        bit  busy_ok;
        n = 0;
        while ((busy || ready) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        exp_q.push_back({edz, er, erem});
        @(posedge clk); #1;
        check("busy_on_accept", {31'd0, busy}, 32'd1);
        dividend = ~a;
        divisor  = ~b;
        if (!hold) start = 1'b0;
        busy_ok = 1'b1;
        n = 1;
        while (n < LAT + 4) begin
            @(posedge clk); #1;
            if (ready) break;
            if (!busy) busy_ok = 1'b0;
            n++;
        end
        check("latency", n, LAT);
        check("busy_during_run", {31'd0, busy_ok}, 32'd1);
        if (hold) begin
            repeat (3) begin
                @(posedge clk); #1;
                check("ready_held", {31'd0, ready}, 32'd1);
                check("no_second_busy", {31'd0, busy}, 32'd0);
            end
            @(negedge clk);
            start = 1'b0;
        end
        @(posedge clk); #1;
        check("ready_drop", {31'd0, ready}, 32'd0);
        check("div_zero_clear", {31'd0, div_zero}, 32'd0);
        check("result_hold", {16'd0, result}, {16'd0, er});
        check("remainder_hold", {16'd0, remainder}, {16'd0, erem});
    endtask

    task automatic abort_mid_run();
        @(negedge clk);
        dividend = 16'd730;
        divisor  = 16'd100;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_ready", {31'd0, ready}, 32'd0);
        check("abort_result", {16'd0, result}, 32'd0);
        check("abort_remainder", {16'd0, remainder}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        start = 1'b0;
        dividend = '0;
        divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_result", {16'd0, result}, 32'd0);
        check("rst_remainder", {16'd0, remainder}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_div_zero", {31'd0, div_zero}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        do_div(16'd730,   16'd100, 16'd7,      16'd30,   1'b0, 1'b0);
        do_div(16'd1000,  16'd0,   16'hFFFF,   16'd1000, 1'b1, 1'b0);
        do_div(16'd0,     16'd5,   16'd0,      16'd0,    1'b0, 1'b0);
        do_div(16'd65535, 16'd1,   16'd65535,  16'd0,    1'b0, 1'b0);
        do_div(16'd5,     16'd9,   RND ? 16'd1 : 16'd0, 16'd5, 1'b0, 1'b0);
        do_div(16'd750,   16'd100, RND ? 16'd8 : 16'd7, 16'd50, 1'b0, 1'b0);
        do_div(16'd749,   16'd100, 16'd7,      16'd49,   1'b0, 1'b0);
        do_div(16'd65535, 16'd2,   RND ? 16'd32768 : 16'd32767, 16'd1, 1'b0, 1'b0);
        do_div(16'd730,   16'd100, 16'd7,      16'd30,   1'b0, 1'b1);
        do_div(16'd1000,  16'd0,   16'hFFFF,   16'd1000, 1'b1, 1'b1);
        abort_mid_run();
        do_div(16'd730,   16'd100, 16'd7,      16'd30,   1'b0, 1'b0);

        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("queue_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
